// File: rtl/lif_array_if.sv
// Handshake and probe bundle for lif_array: input-current beats, spike-vector output, state probe.
interface lif_array_if #(
    parameter int WIDTH     = 16,
    parameter int N_NEURONS = 4
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_current;
    logic                 learnable_threshold;
    logic                 learnable_beta;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_NEURONS-1:0] out_spikes;
    logic [IW-1:0]        probe_idx;
    logic [WIDTH-1:0]     probe_state;

    modport slave (
        input  in_valid, in_current, learnable_threshold, learnable_beta,
               out_ready, probe_idx,
        output in_ready, out_valid, out_spikes, probe_state
    );

    modport master (
        output in_valid, in_current, learnable_threshold, learnable_beta,
               out_ready, probe_idx,
        input  in_ready, out_valid, out_spikes, probe_state
    );
endinterface

// File: rtl/lif_array.sv
// Time-multiplexed leaky integrate-and-fire array: one neuron per accepted beat, one spike vector per timestep.
// Optional feature: define LIF_REFRACTORY_EN to add per-neuron refractory counters.
module lif_array #(
    parameter int WIDTH       = 16,
    parameter int N_NEURONS   = 4,
    parameter int THRESH_INIT = 100,
    parameter int THRESH_MIN  = 8,
    parameter int THRESH_MAX  = 220,
    parameter int BETA_INIT   = 224,
    parameter int ADAPT_INC   = 295,
    parameter int ADAPT_DEC   = 244,
    parameter int REFRACT     = 2
) (
    input logic        clk,
    input logic        rst_n,
    lif_array_if.slave io
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int TW = WIDTH + 9;

    localparam logic [IW-1:0]    LAST_IDX = IW'(N_NEURONS - 1);
    localparam logic [WIDTH-1:0] T_INIT   = WIDTH'(THRESH_INIT);
    localparam logic [WIDTH-1:0] T_MIN    = WIDTH'(THRESH_MIN);
    localparam logic [WIDTH-1:0] T_MAX    = WIDTH'(THRESH_MAX);
    localparam logic [TW-1:0]    T_INC_K  = TW'(ADAPT_INC);
    localparam logic [TW-1:0]    T_DEC_K  = TW'(ADAPT_DEC);
    localparam logic [16:0]      B_INC_K  = 17'(ADAPT_INC);
    localparam logic [16:0]      B_DEC_K  = 17'(ADAPT_DEC);
    localparam logic [7:0]       B_INIT   = 8'(BETA_INIT);

    logic [WIDTH-1:0]     state_q [N_NEURONS];
    logic [WIDTH-1:0]     thr_q   [N_NEURONS];
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           beta_q, beta_d;
    logic [N_NEURONS-1:0] acc_q, acc_d;
    logic [N_NEURONS-1:0] spikes_q, spikes_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     probe_q, probe_d;

    logic                 last, in_ready, fire;
    logic [WIDTH-1:0]     cur_state, cur_thr;
    logic                 refr_active, spike;
    logic [WIDTH+7:0]     decay_prod;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     integ;
    logic [TW-1:0]        thr_up_prod, thr_dn_prod;
    logic [16:0]          beta_up_prod, beta_dn_prod;
    logic [WIDTH-1:0]     state_nxt, thr_nxt;
    logic [N_NEURONS-1:0] spike_vec;

    assign last      = (idx_q == LAST_IDX);
    assign in_ready  = !(last && out_valid_q && !io.out_ready);
    assign fire      = io.in_valid && in_ready;
    assign cur_state = state_q[idx_q];
    assign cur_thr   = thr_q[idx_q];

`ifdef LIF_REFRACTORY_EN
    localparam int RW = $clog2(REFRACT + 2);

    logic [RW-1:0] refr_q [N_NEURONS];
    logic [RW-1:0] cur_refr, refr_nxt;

    assign cur_refr    = refr_q[idx_q];
    assign refr_active = (cur_refr != '0);

    always_comb begin
        refr_nxt = cur_refr;
        if (refr_active)
            refr_nxt = cur_refr - 1'b1;
        else if (spike)
            refr_nxt = RW'(REFRACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_NEURONS; i++)
                refr_q[i] <= '0;
        end else if (fire) begin
            refr_q[idx_q] <= refr_nxt;
        end
    end
`else
    assign refr_active = 1'b0;
`endif

    // Spike is decided on the stored state, before this beat's integration.
    assign spike = !refr_active && (cur_state >= cur_thr);

    assign decay_prod   = {8'b0, cur_state} * {{WIDTH{1'b0}}, beta_q};
    assign sum          = {1'b0, io.in_current} + {1'b0, decay_prod[WIDTH+7:8]};
    assign integ        = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign thr_up_prod  = {9'b0, cur_thr} * T_INC_K;
    assign thr_dn_prod  = {9'b0, cur_thr} * T_DEC_K;
    assign beta_up_prod = {9'b0, beta_q} * B_INC_K;
    assign beta_dn_prod = {9'b0, beta_q} * B_DEC_K;

    always_comb begin
        state_nxt = (refr_active || spike) ? '0 : integ;
        thr_nxt   = cur_thr;
        if (!refr_active && io.learnable_threshold) begin
            if (spike && (cur_thr < T_MAX))
                thr_nxt = thr_up_prod[WIDTH+7:8];
            else if (!spike && (cur_thr > T_MIN))
                thr_nxt = thr_dn_prod[WIDTH+7:8];
        end
    end

    always_comb begin
        spike_vec        = acc_q;
        spike_vec[idx_q] = spike;
    end

    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        spikes_d    = spikes_q;
        beta_d      = beta_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && io.out_ready)
            out_valid_d = 1'b0;
        if (fire) begin
            if (last) begin
                idx_d       = '0;
                acc_d       = '0;
                spikes_d    = spike_vec;
                out_valid_d = 1'b1;
                if (io.learnable_beta) begin
                    if ((|spike_vec) && (beta_q < 8'd220))
                        beta_d = beta_up_prod[15:8];
                    else if (!(|spike_vec) && (beta_q > 8'd128))
                        beta_d = beta_dn_prod[15:8];
                end
            end else begin
                idx_d = idx_q + 1'b1;
                acc_d = spike_vec;
            end
        end
    end

    always_comb begin
        probe_d = '0;
        if (io.probe_idx <= LAST_IDX)
            probe_d = state_q[io.probe_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                thr_q[i]   <= T_INIT;
            end
        end else if (fire) begin
            state_q[idx_q] <= state_nxt;
            thr_q[idx_q]   <= thr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            acc_q       <= '0;
            spikes_q    <= '0;
            beta_q      <= B_INIT;
            out_valid_q <= 1'b0;
            probe_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            spikes_q    <= spikes_d;
            beta_q      <= beta_d;
            out_valid_q <= out_valid_d;
            probe_q     <= probe_d;
        end
    end

    assign io.in_ready    = in_ready;
    assign io.out_valid   = out_valid_q;
    assign io.out_spikes  = spikes_q;
    assign io.probe_state = probe_q;

    logic unused_bits;
    assign unused_bits = ^{decay_prod[7:0], thr_up_prod[TW-1], thr_up_prod[7:0],
                           thr_dn_prod[TW-1], thr_dn_prod[7:0],
                           beta_up_prod[16], beta_up_prod[7:0],
                           beta_dn_prod[16], beta_dn_prod[7:0]};
endmodule

// File: tb/tb_lif_array.sv
// Randomized self-checking bench for lif_array against an arithmetic reference model.
module tb_lif_array;
    localparam int W       = 16;
    localparam int N       = 4;
    localparam int TINIT   = 100;
    localparam int TMIN    = 8;
    localparam int TMAX    = 220;
    localparam int BINIT   = 224;
    localparam int INC     = 295;
    localparam int DEC     = 244;
    localparam int REFR    = 2;
    localparam int SAT     = (1 << W) - 1;

    logic clk;
    logic rst_n;

    lif_array_if #(.WIDTH(W), .N_NEURONS(N)) io ();

    lif_array #(
        .WIDTH(W), .N_NEURONS(N), .THRESH_INIT(TINIT), .THRESH_MIN(TMIN),
        .THRESH_MAX(TMAX), .BETA_INIT(BINIT), .ADAPT_INC(INC),
        .ADAPT_DEC(DEC), .REFRACT(REFR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    int m_state [N];
    int m_thr   [N];
    int m_refr  [N];
    int m_beta, m_idx, m_acc, m_ov, m_os;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_thr[i]   = TINIT;
            m_refr[i]  = 0;
        end
        m_beta = BINIT;
        m_idx  = 0;
        m_acc  = 0;
        m_ov   = 0;
        m_os   = 0;
    endtask

    function automatic int m_ready(input int ordy);
        return !(m_idx == N - 1 && m_ov != 0 && ordy == 0);
    endfunction

    task automatic model_edge(input int v, input int c, input int lt, input int lb, input int ordy);
        int fire, i, sp, s, hold;
        fire = v && m_ready(ordy);
        if (m_ov != 0 && ordy != 0) m_ov = 0;
        if (fire) begin
            i    = m_idx;
            sp   = 0;
            hold = 0;
`ifdef LIF_REFRACTORY_EN
            hold = (m_refr[i] > 0);
`endif
            if (hold) begin
                m_refr[i] = m_refr[i] - 1;
                m_state[i] = 0;
            end else begin
                sp = (m_state[i] >= m_thr[i]);
                if (sp) begin
                    m_state[i] = 0;
`ifdef LIF_REFRACTORY_EN
                    m_refr[i] = REFR;
`endif
                    if (lt && m_thr[i] < TMAX) m_thr[i] = ((m_thr[i] * INC) / 256) % (SAT + 1);
                end else begin
                    s = c + (m_state[i] * m_beta) / 256;
                    m_state[i] = (s > SAT) ? SAT : s;
                    if (lt && m_thr[i] > TMIN) m_thr[i] = (m_thr[i] * DEC) / 256;
                end
            end
            if (sp) m_acc = m_acc | (1 << i);
            if (i == N - 1) begin
                m_os = m_acc;
                m_ov = 1;
                if (lb) begin
                    if (m_acc != 0 && m_beta < 220) m_beta = (m_beta * INC) / 256;
                    else if (m_acc == 0 && m_beta > 128) m_beta = (m_beta * DEC) / 256;
                end
                m_acc = 0;
                m_idx = 0;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input int v, input int c, input int lt, input int lb,
                         input int ordy, input int pidx);
        int pexp;
        io.in_valid            = v[0];
        io.in_current          = W'(c);
        io.learnable_threshold = lt[0];
        io.learnable_beta      = lb[0];
        io.out_ready           = ordy[0];
        io.probe_idx           = pidx[1:0];
        #1;
        check("in_ready", int'(io.in_ready), m_ready(ordy));
        pexp = m_state[pidx];
        @(posedge clk);
        model_edge(v, c, lt, lb, ordy);
        #1;
        check("out_valid", int'(io.out_valid), m_ov);
        check("out_spikes", int'(io.out_spikes), m_os);
        check("probe_state", int'(io.probe_state), pexp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n                  = 1'b0;
        io.in_valid            = 1'b0;
        io.in_current          = '0;
        io.learnable_threshold = 1'b0;
        io.learnable_beta      = 1'b0;
        io.out_ready           = 1'b0;
        io.probe_idx           = '0;
        model_reset();
        do_reset();

        check("rst_out_valid", int'(io.out_valid), 0);
        check("rst_out_spikes", int'(io.out_spikes), 0);
        check("rst_probe", int'(io.probe_state), 0);
        check("rst_in_ready", int'(io.in_ready), 1);

        // Integrate-and-fire on neuron 0 with constant current 60.
        for (int t = 1; t <= 6; t++) begin
            for (int n = 0; n < N; n++) cycle(1, (n == 0) ? 60 : 0, 0, 0, 1, 0);
            if (t == 1) check("if_step1_state", int'(io.probe_state), 60);
            if (t == 2) check("if_step2_state", int'(io.probe_state), 112);
            if (t == 3) begin
                check("if_step3_spikes", int'(io.out_spikes), 1);
                check("if_step3_state", int'(io.probe_state), 0);
            end
        end

        // Idle decay with threshold learning.
        for (int t = 0; t < 3; t++) begin
            for (int n = 0; n < N; n++) cycle(1, 0, 1, 0, 1, n);
            check("idle_spikes", int'(io.out_spikes), 0);
        end

        // Saturation: large currents into neuron 1.
        for (int t = 0; t < 3; t++)
            for (int n = 0; n < N; n++) cycle(1, (n == 1) ? 40000 : 0, 0, 0, 1, 1);

        // Backpressure across two timesteps, then release on the stalled beat.
        cycle(0, 0, 0, 0, 1, 0);
        for (int b = 0; b < 2 * N - 1; b++) cycle(1, 30, 1, 1, 0, 0);
        cycle(1, 30, 1, 1, 0, 0);
        check("bp_stall_ready", int'(io.in_ready), 0);
        check("bp_stall_valid", int'(io.out_valid), 1);
        cycle(1, 30, 1, 1, 1, 0);
        check("bp_reload_valid", int'(io.out_valid), 1);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            int c;
            c = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SAT)) : int'($urandom_range(0, 90));
            cycle(($urandom_range(0, 3) != 0) ? 1 : 0, c, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, N - 1)));
        end

        // Asynchronous reset in the middle of a timestep.
        cycle(0, 0, 0, 0, 1, 0);
        for (int b = 0; b < N; b++) cycle(1, 50, 0, 0, 0, 0);
        cycle(1, 50, 0, 0, 0, 0);
        cycle(1, 50, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(io.out_valid), 0);
        check("arst_out_spikes", int'(io.out_spikes), 0);
        check("arst_probe", int'(io.probe_state), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 70, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        check("arst_first_beat", int'(io.probe_state), 70);

        for (int k = 0; k < 200; k++)
            cycle(1, int'($urandom_range(0, 120)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, N - 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
